// File: rtl/sd_fifo_pkg.sv
// sd_fifo_pkg: shared constants and types for the SD host data FIFO.
//   DIR_TX / DIR_RX        : transfer direction encoding
//   SD_FIFO_DEPTH_DEFAULT  : default word capacity
//   SD_WORD_W / SD_HALF_W  : host word and phy half-word widths
//   phase_e                : which 32-bit half of a word the phy side is on
package sd_fifo_pkg;

    localparam logic DIR_TX = 1'b0;
    localparam logic DIR_RX = 1'b1;

    localparam int unsigned SD_FIFO_DEPTH_DEFAULT = 16;
    localparam int unsigned SD_WORD_W             = 64;
    localparam int unsigned SD_HALF_W             = 32;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_e;

endpackage

// File: rtl/sd_host_fifo_if.sv
// sd_host_fifo_if: bundle of host-side, phy-side and status signals of sd_host_fifo.
//   master modport : driver side (slave FSM + data-line engine)
//   slave modport  : the FIFO itself
//   dir/clear, fifo_write_en/fifo_read_en/host_data_i/host_data_o,
//   phy_write_en/phy_data_i/phy_read_en/phy_data_o,
//   full/empty/count/overflow/underflow (+ almost_full/almost_empty when
//   FIFO_WATERMARK_EN is defined).
interface sd_host_fifo_if
    import sd_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = SD_FIFO_DEPTH_DEFAULT
) ();

    logic                      dir;
    logic                      clear;
    logic                      fifo_write_en;
    logic                      fifo_read_en;
    logic [SD_WORD_W-1:0]      host_data_i;
    logic [SD_WORD_W-1:0]      host_data_o;
    logic                      phy_write_en;
    logic [SD_HALF_W-1:0]      phy_data_i;
    logic                      phy_read_en;
    logic [SD_HALF_W-1:0]      phy_data_o;
    logic                      full;
    logic                      empty;
    logic [$clog2(DEPTH):0]    count;
    logic                      overflow;
    logic                      underflow;
`ifdef FIFO_WATERMARK_EN
    logic                      almost_full;
    logic                      almost_empty;
`endif

    modport slave (
        input  dir, clear,
        input  fifo_write_en, fifo_read_en, host_data_i,
        output host_data_o,
        input  phy_write_en, phy_data_i, phy_read_en,
        output phy_data_o,
        output full, empty, count, overflow, underflow
`ifdef FIFO_WATERMARK_EN
        , output almost_full, almost_empty
`endif
    );

    modport master (
        output dir, clear,
        output fifo_write_en, fifo_read_en, host_data_i,
        input  host_data_o,
        output phy_write_en, phy_data_i, phy_read_en,
        input  phy_data_o,
        input  full, empty, count, overflow, underflow
`ifdef FIFO_WATERMARK_EN
        , input almost_full, almost_empty
`endif
    );

endinterface

// File: rtl/sd_fifo_mem.sv
// sd_fifo_mem: DEPTH x 64-bit storage for the SD host FIFO.
//   i_clk   : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write word
//   i_raddr : read address (asynchronous read)
//   o_rdata : word at i_raddr
// Contents are not reset; occupancy is tracked by the owner.
module sd_fifo_mem
    import sd_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = SD_FIFO_DEPTH_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [SD_WORD_W-1:0]       i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [SD_WORD_W-1:0]       o_rdata
);

    logic [SD_WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sd_host_fifo.sv
// sd_host_fifo: 64-bit word FIFO between the Wishbone slave and the SD
// data-line engine. Host side moves whole words, phy side moves 32-bit halves.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : sd_host_fifo_if.slave (direction, flush, host/phy data, status)
// dir=0 (TX): host pushes words, phy pops them low half first.
// dir=1 (RX): phy pushes low then high half, host pops words.
// Host enables are levels; only their rising edge moves a word.
// Optional macro FIFO_WATERMARK_EN adds almost_full/almost_empty and AFULL_LVL.
module sd_host_fifo
    import sd_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = SD_FIFO_DEPTH_DEFAULT
`ifdef FIFO_WATERMARK_EN
    , parameter int unsigned AFULL_LVL = DEPTH - 2
`endif
) (
    input  logic          i_clk,
    input  logic          i_rst,
    sd_host_fifo_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_full, r_empty;
    logic                 r_ovf, r_unf;
    phase_e               r_phase;
    logic [SD_HALF_W-1:0] r_low;
    logic                 r_wr_en_d, r_rd_en_d;
    logic                 r_dir;
`ifdef FIFO_WATERMARK_EN
    logic                 r_afull, r_aempty;
`endif

    logic                 w_host_wr_ev, w_host_rd_ev;
    logic                 w_flush;
    logic                 w_push_req, w_pop_req;
    logic                 w_push_ok, w_pop_ok;
    logic [SD_WORD_W-1:0] w_push_data;
    logic [SD_WORD_W-1:0] w_head;
    phase_e               w_phase_nxt;
    logic [SD_HALF_W-1:0] w_low_nxt;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [PTR_W-1:0]     w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic                 w_ovf_nxt, w_unf_nxt;

    sd_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_push_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    always_comb begin
        w_host_wr_ev = bus.fifo_write_en & ~r_wr_en_d;
        w_host_rd_ev = bus.fifo_read_en  & ~r_rd_en_d;
        w_flush      = bus.clear | (bus.dir != r_dir);

        w_push_req   = 1'b0;
        w_pop_req    = 1'b0;
        w_push_data  = bus.host_data_i;
        w_phase_nxt  = r_phase;
        w_low_nxt    = r_low;

        if (bus.dir == DIR_TX) begin
            w_push_req = w_host_wr_ev;
            if (bus.phy_read_en) begin
                // A phy read with nothing stored counts as a pop of an empty FIFO.
                if (r_empty) begin
                    w_pop_req = 1'b1;
                end else if (r_phase == PH_LO) begin
                    w_phase_nxt = PH_HI;
                end else begin
                    w_pop_req   = 1'b1;
                    w_phase_nxt = PH_LO;
                end
            end
        end else begin
            w_pop_req = w_host_rd_ev;
            if (bus.phy_write_en) begin
                if (r_phase == PH_LO) begin
                    w_low_nxt   = bus.phy_data_i;
                    w_phase_nxt = PH_HI;
                end else begin
                    w_push_req  = 1'b1;
                    w_push_data = {bus.phy_data_i, r_low};
                    w_phase_nxt = PH_LO;
                end
            end
        end

        // A pop in the same cycle frees the slot a full FIFO needs for the push.
        w_pop_ok  = w_pop_req & ~r_empty;
        w_push_ok = w_push_req & (~r_full | w_pop_ok);
        w_ovf_nxt = r_ovf | (w_push_req & ~w_push_ok);
        w_unf_nxt = r_unf | (w_pop_req & r_empty);

        if (w_flush) begin
            w_push_ok   = 1'b0;
            w_pop_ok    = 1'b0;
            w_phase_nxt = PH_LO;
            w_low_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_unf_nxt   = 1'b0;
        end

        w_count_nxt  = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_push_ok);
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop_ok);

        if (w_flush) begin
            w_count_nxt  = '0;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_phase   <= PH_LO;
            r_low     <= '0;
            r_wr_en_d <= 1'b0;
            r_rd_en_d <= 1'b0;
            r_dir     <= DIR_TX;
        end else begin
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_count   <= w_count_nxt;
            r_full    <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty   <= (w_count_nxt == '0);
            r_ovf     <= w_ovf_nxt;
            r_unf     <= w_unf_nxt;
            r_phase   <= w_phase_nxt;
            r_low     <= w_low_nxt;
            r_wr_en_d <= bus.fifo_write_en;
            r_rd_en_d <= bus.fifo_read_en;
            r_dir     <= bus.dir;
        end
    end

`ifdef FIFO_WATERMARK_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_afull  <= (w_count_nxt >= CNT_W'(AFULL_LVL));
            r_aempty <= (w_count_nxt <= CNT_W'(1));
        end
    end

    assign bus.almost_full  = r_afull;
    assign bus.almost_empty = r_aempty;
`endif

    assign bus.host_data_o = r_empty ? '0 : w_head;
    assign bus.phy_data_o  = r_empty ? '0 :
                             (r_phase == PH_HI) ? w_head[SD_WORD_W-1:SD_HALF_W]
                                                : w_head[SD_HALF_W-1:0];
    assign bus.full        = r_full;
    assign bus.empty       = r_empty;
    assign bus.count       = r_count;
    assign bus.overflow    = r_ovf;
    assign bus.underflow   = r_unf;

endmodule

// File: tb/tb_sd_host_fifo.sv
// tb_sd_host_fifo: self-checking bench for sd_host_fifo (DEPTH=16).
// Directed vector table, hand-written corner sequences, then randomized
// traffic checked against a queue-based reference model.
module tb_sd_host_fifo;
    import sd_fifo_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sd_host_fifo_if #(.DEPTH(DEPTH)) bus ();

    sd_host_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [63:0] q[$];
    bit          m_phase, m_pwe, m_pre, m_pdir, m_ovf, m_unf;
    logic [31:0] m_low;

    task automatic model_reset();
        q.delete();
        m_phase = 0; m_pwe = 0; m_pre = 0; m_pdir = 0;
        m_ovf = 0; m_unf = 0; m_low = '0;
    endtask

    // Called at each rising edge with the inputs that were held during the cycle.
    task automatic model_step();
        bit wev, rev, push, pop, was_full, popped;
        logic [63:0] pd;
        wev = bus.fifo_write_en && !m_pwe;
        rev = bus.fifo_read_en && !m_pre;
        push = 0; pop = 0; popped = 0;
        pd = bus.host_data_i;
        m_pwe = bus.fifo_write_en;
        m_pre = bus.fifo_read_en;
        if (bus.clear || bus.dir != m_pdir) begin
            m_pdir = bus.dir;
            q.delete();
            m_phase = 0; m_low = '0; m_ovf = 0; m_unf = 0;
            return;
        end
        if (bus.dir == DIR_TX) begin
            push = wev;
            if (bus.phy_read_en) begin
                if (q.size() == 0) pop = 1;
                else if (!m_phase) m_phase = 1;
                else begin pop = 1; m_phase = 0; end
            end
        end else begin
            pop = rev;
            if (bus.phy_write_en) begin
                if (!m_phase) begin m_low = bus.phy_data_i; m_phase = 1; end
                else begin push = 1; pd = {bus.phy_data_i, m_low}; m_phase = 0; end
            end
        end
        was_full = (q.size() == DEPTH);
        if (pop) begin
            if (q.size() == 0) m_unf = 1;
            else begin void'(q.pop_front()); popped = 1; end
        end
        if (push) begin
            if (!was_full || popped) q.push_back(pd);
            else m_ovf = 1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] eh;
        logic [31:0] ep;
        logic [63:0] hd;
        eh = '0; ep = '0;
        if (q.size() != 0) begin
            hd = q[0];
            eh = hd;
            ep = m_phase ? hd[63:32] : hd[31:0];
        end
        chk({tag, ".count"}, 64'(bus.count), 64'(q.size()));
        chk({tag, ".empty"}, 64'(bus.empty), 64'(q.size() == 0));
        chk({tag, ".full"},  64'(bus.full),  64'(q.size() == DEPTH));
        chk({tag, ".ovf"},   64'(bus.overflow),  64'(m_ovf));
        chk({tag, ".unf"},   64'(bus.underflow), 64'(m_unf));
        chk({tag, ".hdo"},   bus.host_data_o, eh);
        chk({tag, ".pdo"},   64'(bus.phy_data_o), 64'(ep));
`ifdef FIFO_WATERMARK_EN
        chk({tag, ".afull"},  64'(bus.almost_full),  64'(q.size() >= DEPTH - 2));
        chk({tag, ".aempty"}, 64'(bus.almost_empty), 64'(q.size() <= 1));
`endif
    endtask

    // ---------------- drive helpers ----------------
    task automatic idle(input logic d);
        bus.dir = d; bus.clear = 0;
        bus.fifo_write_en = 0; bus.fifo_read_en = 0; bus.host_data_i = '0;
        bus.phy_write_en = 0; bus.phy_read_en = 0; bus.phy_data_i = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".count"}, 64'(bus.count), 64'd0);
        chk({tag, ".empty"}, 64'(bus.empty), 64'd1);
        chk({tag, ".full"},  64'(bus.full),  64'd0);
        chk({tag, ".ovf"},   64'(bus.overflow),  64'd0);
        chk({tag, ".unf"},   64'(bus.underflow), 64'd0);
        chk({tag, ".hdo"},   bus.host_data_o, 64'd0);
        chk({tag, ".pdo"},   64'(bus.phy_data_o), 64'd0);
`ifdef FIFO_WATERMARK_EN
        chk({tag, ".afull"},  64'(bus.almost_full),  64'd0);
        chk({tag, ".aempty"}, 64'(bus.almost_empty), 64'd1);
`endif
    endtask

    task automatic do_reset();
        rst = 1;
        idle(DIR_TX);
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 0;
        model_reset();
    endtask

    task automatic host_push(input logic [63:0] w);
        bus.host_data_i = w; bus.fifo_write_en = 1; cycle();
        bus.fifo_write_en = 0; cycle();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        dir, clr, we, re, pwe, pre;
        logic [63:0] hd;
        logic [31:0] pd;
        logic [4:0]  ecnt;
        logic        eempty, efull, eovf, eunf;
        logic [63:0] ehdo;
        logic [31:0] epdo;
    } vec_t;

    vec_t tv[$];

    initial begin
        logic [63:0] w;
        int unsigned cnt;

        tv.push_back('{0,0,1,0,0,0, 64'h1122334455667788, 32'h0, 5'd1, 0,0,0,0, 64'h1122334455667788, 32'h55667788});
        tv.push_back('{0,0,1,0,0,0, 64'h1122334455667788, 32'h0, 5'd1, 0,0,0,0, 64'h1122334455667788, 32'h55667788});
        tv.push_back('{0,0,1,0,0,0, 64'h1122334455667788, 32'h0, 5'd1, 0,0,0,0, 64'h1122334455667788, 32'h55667788});
        tv.push_back('{0,0,0,0,0,1, 64'h0, 32'h0, 5'd1, 0,0,0,0, 64'h1122334455667788, 32'h11223344});
        tv.push_back('{0,0,0,0,0,1, 64'h0, 32'h0, 5'd0, 1,0,0,0, 64'h0, 32'h0});
        tv.push_back('{1,0,0,0,0,0, 64'h0, 32'h0, 5'd0, 1,0,0,0, 64'h0, 32'h0});
        tv.push_back('{1,0,0,0,1,0, 64'h0, 32'hCAFEF00D, 5'd0, 1,0,0,0, 64'h0, 32'h0});
        tv.push_back('{1,0,0,0,1,0, 64'h0, 32'hDEADBEEF, 5'd1, 0,0,0,0, 64'hDEADBEEFCAFEF00D, 32'hCAFEF00D});
        tv.push_back('{1,0,0,1,0,0, 64'h0, 32'h0, 5'd0, 1,0,0,0, 64'h0, 32'h0});
        tv.push_back('{1,0,0,1,0,0, 64'h0, 32'h0, 5'd0, 1,0,0,0, 64'h0, 32'h0});
        tv.push_back('{1,0,0,0,0,0, 64'h0, 32'h0, 5'd0, 1,0,0,0, 64'h0, 32'h0});
        tv.push_back('{1,0,0,1,0,0, 64'h0, 32'h0, 5'd0, 1,0,0,1, 64'h0, 32'h0});
        tv.push_back('{1,1,0,0,0,0, 64'h0, 32'h0, 5'd0, 1,0,0,0, 64'h0, 32'h0});

        model_reset();
        do_reset();

        foreach (tv[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            bus.dir = tv[i].dir; bus.clear = tv[i].clr;
            bus.fifo_write_en = tv[i].we; bus.fifo_read_en = tv[i].re;
            bus.phy_write_en = tv[i].pwe; bus.phy_read_en = tv[i].pre;
            bus.host_data_i = tv[i].hd; bus.phy_data_i = tv[i].pd;
            cycle();
            chk({t, ".count"}, 64'(bus.count), 64'(tv[i].ecnt));
            chk({t, ".empty"}, 64'(bus.empty), 64'(tv[i].eempty));
            chk({t, ".full"},  64'(bus.full),  64'(tv[i].efull));
            chk({t, ".ovf"},   64'(bus.overflow),  64'(tv[i].eovf));
            chk({t, ".unf"},   64'(bus.underflow), 64'(tv[i].eunf));
            chk({t, ".hdo"},   bus.host_data_o, tv[i].ehdo);
            chk({t, ".pdo"},   64'(bus.phy_data_o), 64'(tv[i].epdo));
        end

        // Host read: head valid in the cycle fifo_read_en rises, pop at next edge.
        idle(DIR_RX);
        bus.phy_write_en = 1; bus.phy_data_i = 32'h0BAD_F00D; cycle();
        bus.phy_data_i = 32'h1234_5678; cycle();
        bus.phy_write_en = 0;
        bus.fifo_read_en = 1;
        #1;
        chk("rdsame.hdo", bus.host_data_o, 64'h12345678_0BADF00D);
        cycle();
        chk("rdsame.empty", 64'(bus.empty), 64'd1);
        bus.fifo_read_en = 0; cycle();

        // Full / overflow: 17 pushes, only the first 16 come back.
        do_reset();
        for (int i = 0; i <= 16; i++) host_push(64'hA5A5_0000_0000_0000 | 64'(i));
        chk("full.full",  64'(bus.full), 64'd1);
        chk("full.count", 64'(bus.count), 64'd16);
        chk("full.ovf",   64'(bus.overflow), 64'd1);
        for (int i = 0; i < 16; i++) begin
            w = 64'hA5A5_0000_0000_0000 | 64'(i);
            chk($sformatf("drain%0d.hdo", i), bus.host_data_o, w);
            chk($sformatf("drain%0d.lo", i), 64'(bus.phy_data_o), 64'(w[31:0]));
            bus.phy_read_en = 1; cycle();
            chk($sformatf("drain%0d.hi", i), 64'(bus.phy_data_o), 64'(w[63:32]));
            cycle();
            bus.phy_read_en = 0;
        end
        chk("drain.empty", 64'(bus.empty), 64'd1);
        chk("drain.hdo",   bus.host_data_o, 64'd0);

        // Flush on dir change with 3 words stored and phase=1.
        do_reset();
        for (int i = 0; i < 3; i++) host_push(64'hF0F0_0000_0000_0010 + 64'(i));
        bus.phy_read_en = 1; cycle(); bus.phy_read_en = 0;
        chk("flush.pre_pdo", 64'(bus.phy_data_o), 64'hF0F0_0000);
        bus.dir = DIR_RX; cycle();
        chk("flush.count", 64'(bus.count), 64'd0);
        chk("flush.empty", 64'(bus.empty), 64'd1);
        chk("flush.ovf",   64'(bus.overflow), 64'd0);
        chk("flush.unf",   64'(bus.underflow), 64'd0);
        bus.phy_write_en = 1; bus.phy_data_i = 32'h0000_0001; cycle();
        chk("flush.half", 64'(bus.count), 64'd0);
        bus.phy_data_i = 32'h0000_0002; cycle();
        bus.phy_write_en = 0;
        chk("flush.word", bus.host_data_o, 64'h00000002_00000001);

        // Asynchronous reset mid-transfer, checked before any clock edge.
        do_reset();
        host_push(64'h0123_4567_89AB_CDEF);
        host_push(64'h1111_2222_3333_4444);
        bus.phy_read_en = 1; cycle(); bus.phy_read_en = 0;
        #2;
        rst = 1;
        #1;
        check_reset_vals("asyncrst");
        idle(DIR_TX);
        @(posedge clk); #1;
        rst = 0;
        model_reset();

`ifdef FIFO_WATERMARK_EN
        do_reset();
        for (int i = 0; i < 13; i++) host_push(64'(i));
        chk("wm.afull13", 64'(bus.almost_full), 64'd0);
        host_push(64'd13);
        chk("wm.count14", 64'(bus.count), 64'd14);
        chk("wm.afull14", 64'(bus.almost_full), 64'd1);
        bus.phy_read_en = 1; cycle(); cycle(); bus.phy_read_en = 0;
        chk("wm.afull_pop", 64'(bus.almost_full), 64'd0);
        chk("wm.aempty13", 64'(bus.almost_empty), 64'd0);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            int unsigned bias;
            bias = ((c / 400) % 2 == 0) ? 3 : 1;
            if ($urandom_range(0, 99) == 0) bus.dir = ~bus.dir;
            bus.clear         = ($urandom_range(0, 149) == 0);
            bus.fifo_write_en = ($urandom_range(0, 3) < 4 - bias);
            bus.fifo_read_en  = ($urandom_range(0, 3) < bias);
            bus.phy_write_en  = ($urandom_range(0, 3) < 4 - bias);
            bus.phy_read_en   = ($urandom_range(0, 3) < bias);
            bus.host_data_i   = {$urandom, $urandom};
            bus.phy_data_i    = $urandom;
            cycle();
            check_model($sformatf("rnd%0d", c));
            if (q.size() == DEPTH) cnt++;
        end
        chk("rnd.reached_full", 64'(cnt != 0), 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
